dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache that answers the execute stage's `dcache_*` requests and forwards misses and all stores to a backing memory port. It sits between the pipeline and memory: pipeline-facing request inputs, registered `dcache_dout`, and a `stall` output that freezes the pipeline until each request completes. Lines are one 32-bit word. Tags, valid bits and data are held in flops.

## Interface
- `LINES`, 16: number of lines; power of 2, ≥2. `IDX = log2(LINES)`.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. 0 = reset.
- `dcache_addr` in 32: byte address. Index is `addr[IDX+1:2]`; tag is `addr[31:IDX+2]`; `addr[1:0]` is ignored.
- `dcache_we` in 4: byte write mask. Nonzero means store.
- `dcache_re` in 1: load request.
- `dcache_din` in 32: store data, already lane-aligned.
- `dcache_dout` out 32: load data, registered.
- `stall` out 1: pipeline hold.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_we` out 4: byte mask; `0000` = read.
- `mem_req_addr` out 32: `{dcache_addr[31:2],2'b00}`.
- `mem_req_data` out 32: equals `dcache_din`.
- `mem_resp_valid` in 1: read data valid.
- `mem_resp_data` in 32: read data.

## Operation
- Request present: `req = dcache_re | (|dcache_we)`. A store takes priority if `re` and `we` are both set.
- `hit = valid[idx] & (tag[idx] == addr tag)`. It is combinational from `dcache_addr`.
- The pipeline holds all request inputs stable while `stall` = 1.
- `stall = (IDLE & ((re & !hit) | (|we))) | RD_REQ | RD_WAIT | WR_REQ`. It is combinational and is 0 in WR_DONE.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_DONE.
  - **IDLE**
    - Load hit: `dcache_dout <= data[idx]`; stay in IDLE.
    - Load miss: go to RD_REQ.
    - Store: go to WR_REQ.
    - No request: stay in IDLE; `dcache_dout` holds.
  - **RD_REQ**: `mem_req_valid` = 1, `mem_req_we` = 0. When `mem_req_ready` = 1, go to RD_WAIT.
  - **RD_WAIT**: on `mem_resp_valid`, write `data[idx] <= mem_resp_data`, write the tag, set `valid[idx] <= 1`, and go to IDLE. The held request then hits in IDLE.
  - **WR_REQ**: `mem_req_valid` = 1, `mem_req_we = dcache_we`. When `mem_req_ready` = 1:
    - if hit, merge enabled bytes of `dcache_din` into `data[idx]`;
    - a miss does not allocate;
    - go to WR_DONE.
  - **WR_DONE**: `stall` = 0, so the pipeline consumes the store. Go to IDLE unconditionally. `dcache_dout` is unchanged.
- `mem_resp_valid` outside RD_WAIT is ignored.
- `mem_req_valid` stays asserted with stable fields until `ready`.

## Timing
- Reset values:
  - state = IDLE
  - all valid bits = 0
  - `dcache_dout` = 0
  - `mem_req_valid` = 0
  - `stall` follows its equation, so it is 1 only if a request is present.
  - Tag and data contents are don't-care.
- Reset mid-operation returns the FSM to IDLE and invalidates all lines. Any partial line write and any pending response are dropped.
- Load hit:
  - `stall` = 0 during the request cycle.
  - `dcache_dout` is valid after that cycle's rising edge, i.e. 1-cycle registered latency.
- Load miss:
  - 1 cycle in IDLE with stall, then RD_REQ for ≥1 cycle, then RD_WAIT for ≥1 cycle, then 1 hit cycle in IDLE.
  - With ready = 1 immediately and the response N cycles after acceptance, total stall is N+2 cycles. Data appears on the edge ending the hit cycle.
- Store: IDLE (1 cycle stall), WR_REQ (≥1 cycle), WR_DONE (stall = 0). With immediate ready, total is 2 stall cycles.
- Back-to-back hits sustain 1 request per cycle with `stall` = 0.
- A read hit in WR_DONE is not serviced there. The next request is evaluated in IDLE on the following cycle.

## Test plan
- **Cold read miss.** Reset, then `re` = 1 at addr 0x100. `mem_req_valid` goes high with addr 0x100 and we = 0. `mem_resp_data` = 0xDEADBEEF arrives 3 cycles after ready. Required: `stall` is high for 5 cycles, `dcache_dout` = 0xDEADBEEF after the first unstalled edge, and `valid[0]` = 1.
- **Read hit.** Read 0x100 again. Required: no `mem_req_valid`, `stall` = 0, `dcache_dout` = 0xDEADBEEF after 1 edge.
- **Write hit with mask.** we = 0011, din = 0x12345678, addr 0x100, ready = 1. Required: memory request with we = 0011 and data 0x12345678, stall for 2 cycles. A following read of 0x100 hits and returns 0xDEAD5678.
- **Write miss, no allocate.** Store to 0x200. Required: a memory write occurs. A following read of 0x200 misses (issues `mem_req`).
- **Conflict eviction.** With LINES = 16, read 0x140 after 0x100 is cached. Required: a miss occurs and the line is replaced. Re-reading 0x100 misses again.
- **Reset mid-miss.** Assert `reset` = 0 while in RD_WAIT. Required: `mem_req_valid` = 0 and `dcache_dout` = 0 immediately. A late `mem_resp_valid` changes nothing. After release, a read of 0x100 misses.

Source files
------------

// File: rtl/dcache_mem_if.sv
// Memory-side request/response port of the data cache.
// The master is the cache and the slave is the backing memory.
interface dcache_mem_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [3:0]  mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_we,
    output mem_req_addr,
    output mem_req_data,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_we,
    input  mem_req_addr,
    input  mem_req_data,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through no-write-allocate data cache.
// Lines are one word; misses and every store go to memory.
module dcache_ctrl #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dcache_addr,
  input  logic [3:0]  dcache_we,
  input  logic        dcache_re,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  dcache_mem_if.master mem
);
  localparam int IDX = $clog2(LINES);
  localparam int TW  = 30 - IDX;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0]      data_q [LINES];
  logic [TW-1:0]    tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  logic [IDX-1:0] idx;
  logic [TW-1:0]  tag;
  logic is_st, hit, fill, wr_hit, rd_hit;
  logic unused_ok;

  assign idx   = dcache_addr[IDX+1:2];
  assign tag   = dcache_addr[31:IDX+2];
  assign is_st = |dcache_we;
  assign hit   = valid_q[idx] & (tag_q[idx] == tag);

  assign fill   = (state_q == RD_WAIT)
                & mem.mem_resp_valid;
  assign wr_hit = (state_q == WR_REQ)
                & mem.mem_req_ready & hit;
  assign rd_hit = (state_q == IDLE)
                & dcache_re & !is_st & hit;

  assign mem.mem_req_valid = (state_q == RD_REQ)
                           | (state_q == WR_REQ);
  assign mem.mem_req_we    = (state_q == WR_REQ)
                           ? dcache_we : 4'b0000;
  assign mem.mem_req_addr  = {dcache_addr[31:2], 2'b00};
  assign mem.mem_req_data  = dcache_din;
  assign unused_ok         = ^dcache_addr[1:0];

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_st) begin
          stall   = 1'b1;
          state_d = WR_REQ;
        end else if (dcache_re && !hit) begin
          stall   = 1'b1;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        stall = 1'b1;
        if (mem.mem_req_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (mem.mem_resp_valid) state_d = IDLE;
      end
      WR_REQ: begin
        stall = 1'b1;
        if (mem.mem_req_ready) state_d = WR_DONE;
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dcache_dout <= '0;
    end else begin
      state_q <= state_d;
      if (fill) valid_q[idx] <= 1'b1;
      if (rd_hit) dcache_dout <= data_q[idx];
    end
  end

  // Tag/data need no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx] <= mem.mem_resp_data;
      tag_q[idx]  <= tag;
    end else if (wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (dcache_we[b])
          data_q[idx][8*b +: 8] <= dcache_din[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl.
// The bench plays the memory side by hand.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  we;
  logic        re;
  logic [31:0] din;
  logic [31:0] dout;
  logic        stall;

  dcache_mem_if mem();

  dcache_ctrl #(.LINES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .dcache_addr (addr),
    .dcache_we   (we),
    .dcache_re   (re),
    .dcache_din  (din),
    .dcache_dout (dout),
    .stall       (stall),
    .mem         (mem)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  int          stalls;
  logic        saw;
  logic [31:0] raddr;
  logic [31:0] rdat;
  logic [3:0]  rwe;

  // One request; response n cycles after acceptance.
  task automatic access(input logic [31:0] a,
                        input logic [3:0]  w,
                        input logic [31:0] d,
                        input logic        r,
                        input int          n,
                        input logic [31:0] rd);
    int acc;
    bit done;
    acc  = -1;
    done = 0;
    @(negedge clk);
    addr = a; we = w; din = d; re = r;
    stalls = 0; saw = 0;
    raddr = '0; rdat = '0; rwe = '0;
    for (int k = 0; k < 40 && !done; k++) begin
      mem.mem_resp_valid = (acc >= 0) && (k == acc + n);
      mem.mem_resp_data  = rd;
      #1;
      if (mem.mem_req_valid && acc < 0) begin
        saw = 1; acc = k;
        raddr = mem.mem_req_addr;
        rdat  = mem.mem_req_data;
        rwe   = mem.mem_req_we;
      end
      if (!stall) done = 1;
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    mem.mem_resp_valid = 1'b0;
    re = 1'b0; we = 4'b0;
  endtask

  initial begin
    reset = 1'b0;
    addr = '0; we = '0; re = 1'b0; din = '0;
    mem.mem_req_ready  = 1'b1;
    mem.mem_resp_valid = 1'b0;
    mem.mem_resp_data  = '0;
    #1;
    chk("rst_dout", dout, 32'h0);
    chk("rst_mvalid", {31'd0, mem.mem_req_valid}, 32'd0);
    chk("rst_stall_idle", {31'd0, stall}, 32'd0);
    addr = 32'h100; re = 1'b1;
    #1;
    chk("rst_stall_req", {31'd0, stall}, 32'd1);
    re = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    access(32'h100, 4'h0, 0, 1'b1, 3, 32'hDEADBEEF);
    chk("cold_saw", {31'd0, saw}, 32'd1);
    chk("cold_addr", raddr, 32'h100);
    chk("cold_we", {28'd0, rwe}, 32'd0);
    chk("cold_stalls", stalls, 32'd5);
    chk("cold_dout", dout, 32'hDEADBEEF);

    access(32'h100, 4'h0, 0, 1'b1, 1, 32'h0);
    chk("hit_saw", {31'd0, saw}, 32'd0);
    chk("hit_stalls", stalls, 32'd0);
    chk("hit_dout", dout, 32'hDEADBEEF);

    access(32'h100, 4'h3, 32'h12345678, 1'b0, 0, 0);
    chk("wh_we", {28'd0, rwe}, 32'h3);
    chk("wh_data", rdat, 32'h12345678);
    chk("wh_addr", raddr, 32'h100);
    chk("wh_stalls", stalls, 32'd2);
    chk("wh_dout_hold", dout, 32'hDEADBEEF);
    access(32'h100, 4'h0, 0, 1'b1, 1, 32'h0);
    chk("wh_rd_saw", {31'd0, saw}, 32'd0);
    chk("wh_rd_dout", dout, 32'hDEAD5678);

    access(32'h203, 4'hF, 32'hCAFEF00D, 1'b0, 0, 0);
    chk("wm_saw", {31'd0, saw}, 32'd1);
    chk("wm_addr", raddr, 32'h200);
    chk("wm_we", {28'd0, rwe}, 32'hF);
    chk("wm_stalls", stalls, 32'd2);
    access(32'h200, 4'h0, 0, 1'b1, 1, 32'h0BADF00D);
    chk("wm_rd_saw", {31'd0, saw}, 32'd1);
    chk("wm_rd_stalls", stalls, 32'd3);
    chk("wm_rd_dout", dout, 32'h0BADF00D);

    access(32'h100, 4'h0, 0, 1'b1, 2, 32'h11112222);
    chk("refill_stalls", stalls, 32'd4);
    chk("refill_dout", dout, 32'h11112222);
    access(32'h140, 4'h0, 0, 1'b1, 1, 32'h33334444);
    chk("evict_saw", {31'd0, saw}, 32'd1);
    chk("evict_dout", dout, 32'h33334444);
    access(32'h100, 4'h0, 0, 1'b1, 1, 32'h55556666);
    chk("evict_re_saw", {31'd0, saw}, 32'd1);
    chk("evict_re_dout", dout, 32'h55556666);

    access(32'h104, 4'h0, 0, 1'b1, 1, 32'h77778888);
    chk("line1_dout", dout, 32'h77778888);
    access(32'h103, 4'h0, 0, 1'b1, 1, 32'h0);
    chk("line0_keep_saw", {31'd0, saw}, 32'd0);
    chk("line0_keep_dout", dout, 32'h55556666);

    @(negedge clk);
    addr = 32'h140; re = 1'b1;
    mem.mem_req_ready = 1'b0;
    #1;
    chk("mr_idle_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    #1;
    chk("mr_req_valid", {31'd0, mem.mem_req_valid}, 32'd1);
    @(negedge clk);
    #1;
    chk("mr_req_hold", {31'd0, mem.mem_req_valid}, 32'd1);
    chk("mr_req_addr", mem.mem_req_addr, 32'h140);
    mem.mem_req_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("mr_wait_valid", {31'd0, mem.mem_req_valid}, 32'd0);
    chk("mr_wait_stall", {31'd0, stall}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_rst_valid", {31'd0, mem.mem_req_valid}, 32'd0);
    chk("mr_rst_dout", dout, 32'h0);
    chk("mr_rst_stall", {31'd0, stall}, 32'd1);
    re = 1'b0;
    mem.mem_resp_valid = 1'b1;
    mem.mem_resp_data  = 32'h99999999;
    @(negedge clk);
    #1;
    chk("mr_late_dout", dout, 32'h0);
    chk("mr_late_stall", {31'd0, stall}, 32'd0);
    mem.mem_resp_valid = 1'b0;
    reset = 1'b1;

    access(32'h100, 4'h0, 0, 1'b1, 1, 32'hAAAA0001);
    chk("post_rst_saw", {31'd0, saw}, 32'd1);
    chk("post_rst_stalls", stalls, 32'd3);
    chk("post_rst_dout", dout, 32'hAAAA0001);
    access(32'h104, 4'h0, 0, 1'b1, 1, 32'hBBBB0002);
    chk("post_rst_l1_saw", {31'd0, saw}, 32'd1);

    access(32'h100, 4'hC, 32'hFEED0000, 1'b1, 0, 0);
    chk("prio_we", {28'd0, rwe}, 32'hC);
    chk("prio_stalls", stalls, 32'd2);
    chk("prio_dout_hold", dout, 32'hBBBB0002);
    access(32'h100, 4'h0, 0, 1'b1, 1, 32'h0);
    chk("prio_rd_saw", {31'd0, saw}, 32'd0);
    chk("prio_rd_dout", dout, 32'hFEED0001);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
